// File: rtl/mod16_pow_seq.sv
// Computes base^exp mod 16 by MSB-first square-and-multiply over one shared
// 4x4 truncated multiplier, issuing one multiply per clock behind a start/done handshake.
module mod16_pow_seq #(
   parameter int unsigned EXP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [3:0]       base_i,
   input  logic [EXP_W-1:0] exp_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [3:0]       result_o
);

   localparam int unsigned     IdxW   = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam logic [IdxW-1:0] IdxTop = IdxW'(EXP_W - 1);

   typedef enum logic [1:0] {StIdle, StSquare, StMult, StDone} state_e;

   state_e           state_q, state_d;
   logic [3:0]       b_q, b_d;
   logic [EXP_W-1:0] e_q, e_d;
   logic [3:0]       acc_q, acc_d;
   logic [3:0]       result_q, result_d;
   logic [IdxW-1:0]  idx_q, idx_d;

   logic [3:0] mul_a, mul_b, prod;

   // Shared multiplier: square uses acc for both operands, multiply swaps in the base.
   always_comb begin
      mul_a = acc_q;
      mul_b = (state_q == StMult) ? b_q : acc_q;
   end

   assign prod = mul_a * mul_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         b_q      <= 4'd0;
         e_q      <= '0;
         acc_q    <= 4'd1;
         result_q <= 4'd0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         b_q      <= b_d;
         e_q      <= e_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         idx_q    <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      b_d      = b_q;
      e_d      = e_q;
      acc_d    = acc_q;
      result_d = result_q;
      idx_d    = idx_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               b_d     = base_i;
               e_d     = exp_i;
               acc_d   = 4'd1;
               idx_d   = IdxTop;
               state_d = StSquare;
            end
         end
         StSquare: begin
            acc_d = prod;
            if (e_q[idx_q]) begin
               state_d = StMult;
            end else if (idx_q == '0) begin
               result_d = prod;
               state_d  = StDone;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         StMult: begin
            acc_d = prod;
            // Every exit from idx=0 lands in done, so idx never wraps.
            if (idx_q == '0) begin
               result_d = prod;
               state_d  = StDone;
            end else begin
               idx_d   = idx_q - 1'b1;
               state_d = StSquare;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      ready_o  = (state_q == StIdle);
      busy_o   = (state_q == StSquare) || (state_q == StMult);
      done_o   = (state_q == StDone);
      result_o = result_q;
   end

endmodule

// File: tb/tb_mod16_pow_seq.sv
// Directed and exhaustive checks of mod16_pow_seq against a small power-mod-16 model.
module tb_mod16_pow_seq;

   logic       clk;
   logic       rst_n;
   logic       start_i;
   logic [3:0] base_i;
   logic [3:0] exp_i;
   logic       ready_o, busy_o, done_o;
   logic [3:0] result_o;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int done_exp = 0;
   bit mon_en   = 0;

   mod16_pow_seq #(
      .EXP_W (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .base_i   (base_i),
      .exp_i    (exp_i),
      .ready_o  (ready_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [3:0] pow16(input logic [3:0] b, input logic [3:0] e);
      int r = 1;
      for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % 16;
      return 4'(r);
   endfunction

   always @(posedge clk) if (done_o) done_cnt++;

   // Exactly one of ready/busy/done every cycle.
   always @(negedge clk) if (mon_en) chk("onehot", $countones({ready_o, busy_o, done_o}), 1);

   // Called just after a posedge, after the accepting edge; returns cycles until done.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done_o && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic do_job(input string tag, input logic [3:0] b, input logic [3:0] e,
                         input logic [3:0] want);
      int cyc;
      base_i  = b;
      exp_i   = e;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      base_i  = ~b;
      exp_i   = ~e;
      wait_done(cyc);
      done_exp++;
      chk({tag, "_lat"}, cyc, 4 + $countones(e));
      chk({tag, "_res"}, result_o, want);
      @(posedge clk); #1;
      chk({tag, "_rdy"}, {ready_o, done_o}, 2'b10);
   endtask

   initial begin
      int cyc;
      rst_n   = 1'b0;
      start_i = 1'b0;
      base_i  = 4'd0;
      exp_i   = 4'd0;
      #1;
      chk("rst_outs", {ready_o, busy_o, done_o, result_o}, {3'b100, 4'd0});
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      do_job("t1_3p4", 4'd3, 4'd4, 4'd1);
      do_job("t2_3p15", 4'd3, 4'd15, 4'd11);
      do_job("t3_0p0", 4'd0, 4'd0, 4'd1);
      do_job("t3_7p0", 4'd7, 4'd0, 4'd1);
      do_job("t4_2p3", 4'd2, 4'd3, 4'd8);
      do_job("t4_2p4", 4'd2, 4'd4, 4'd0);

      // Start held high with new operands while busy: only the first job runs.
      base_i  = 4'd3;
      exp_i   = 4'd4;
      start_i = 1'b1;
      @(posedge clk); #1;
      base_i = 4'd5;
      exp_i  = 4'd7;
      wait_done(cyc);
      done_exp++;
      chk("t5_lat", cyc, 5);
      chk("t5_res", result_o, 4'd1);
      @(posedge clk); #1;
      chk("t5_rdy", {ready_o, busy_o}, 2'b10);
      @(posedge clk); #1;
      chk("t5_resample", busy_o, 1'b1);
      start_i = 1'b0;
      wait_done(cyc);
      done_exp++;
      chk("t5_lat2", cyc, 7);
      chk("t5_res2", result_o, 4'd13);
      @(posedge clk); #1;

      // Async reset mid-SQUARE aborts the job and clears the result.
      do_job("t6_pre", 4'd3, 4'd15, 4'd11);
      base_i  = 4'd3;
      exp_i   = 4'd15;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("t6_busy", busy_o, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_outs", {ready_o, busy_o, done_o, result_o}, {3'b100, 4'd0});
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_idle", {ready_o, result_o}, {1'b1, 4'd0});
      do_job("t6_post", 4'd6, 4'd3, 4'd8);

      for (int b = 0; b < 16; b++) begin
         for (int e = 0; e < 16; e++) begin
            do_job("sweep", 4'(b), 4'(e), pow16(4'(b), 4'(e)));
         end
      end

      mon_en = 1'b0;
      chk("done_count", done_cnt, done_exp);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
